// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the seven-segment number display.
// Segment bit order 6..0: middle, upper-left, lower-left, bottom, lower-right, upper-right, top.
package seg7_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    // Segments are active-low: 1 = dark.
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1011000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] DASH    = 7'b0111111;
    localparam logic [6:0] DARK    = 7'b1111111;

endpackage

// File: rtl/seg7_number_display_if.sv
// Load handshake, display controls and segment outputs of the number display.
interface seg7_number_display_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NDIG  = 8
);
    logic                  i_valid;
    logic                  o_ready;
    logic [WIDTH-1:0]      i_value;
    logic                  i_blank_lz;
    logic                  i_blink;
    logic [NDIG-1:0][6:0]  o_seg;

    modport master (
        output i_valid, i_value, i_blank_lz, i_blink,
        input  o_ready, o_seg
    );

    modport slave (
        input  i_valid, i_value, i_blank_lz, i_blink,
        output o_ready, o_seg
    );
endinterface

// File: rtl/seg7_glyph.sv
// Combinational BCD digit to seven-segment pattern decoder (active-low segments).
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = DARK;
        case (i_bcd)
            4'd0:    o_seg = GLYPH_0;
            4'd1:    o_seg = GLYPH_1;
            4'd2:    o_seg = GLYPH_2;
            4'd3:    o_seg = GLYPH_3;
            4'd4:    o_seg = GLYPH_4;
            4'd5:    o_seg = GLYPH_5;
            4'd6:    o_seg = GLYPH_6;
            4'd7:    o_seg = GLYPH_7;
            4'd8:    o_seg = GLYPH_8;
            4'd9:    o_seg = GLYPH_9;
            default: o_seg = DARK;
        endcase
    end

endmodule

// File: rtl/seg7_number_display.sv
// Binary-to-decimal seven-segment display: serial double-dabble conversion, one bit per cycle,
// with leading-zero blanking, overflow dashes and a free-running blink gate.
module seg7_number_display
    import seg7_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NDIG      = 8,
    parameter int unsigned BLINK_DIV = 24
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    seg7_number_display_if.slave bus
);

    localparam int unsigned BW = 4 * NDIG;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic                 accept;
    logic                 last_iter;
    logic [WIDTH-1:0]     bin_q;
    logic [BW-1:0]        bcd_q, bcd_adj;
    logic                 ovf_q;
    logic                 blank_q;
    logic [CW-1:0]        cnt_q;
    logic [NDIG-1:0][6:0] disp_q, disp_d, glyph;
    logic [NDIG-1:0]      lead_zero;
    logic                 zero_above;
    logic [BLINK_DIV-1:0] blink_q;

    assign accept    = (state_q == StIdle) && bus.i_valid;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StConv;
            StConv:  if (last_iter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.o_ready = (state_q == StIdle);
    end

    // Add 3 to every digit of 5 or more before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            blank_q <= 1'b0;
            cnt_q   <= '0;
            disp_q  <= {NDIG{DARK}};
        end else if (accept) begin
            bin_q   <= bus.i_value;
            blank_q <= bus.i_blank_lz;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == StConv) begin
            bcd_q   <= {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
            bin_q   <= bin_q << 1;
            ovf_q   <= ovf_q | bcd_adj[BW-1];
            cnt_q   <= cnt_q + 1'b1;
        end else if (state_q == StDone) begin
            disp_q  <= disp_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) blink_q <= '0;
        else          blink_q <= blink_q + 1'b1;
    end

    for (genvar g = 0; g < int'(NDIG); g++) begin : g_digit
        seg7_glyph u_glyph (
            .i_bcd (bcd_q[4*g +: 4]),
            .o_seg (glyph[g])
        );
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        lead_zero  = '0;
        zero_above = 1'b1;
        for (int i = int'(NDIG) - 1; i >= 1; i--) begin
            zero_above   = zero_above && (bcd_q[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_above;
        end
    end

    always_comb begin
        disp_d = glyph;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (ovf_q)                        disp_d[i] = DASH;
            else if (blank_q && lead_zero[i]) disp_d[i] = DARK;
        end
    end

    always_comb begin
        bus.o_seg = (bus.i_blink && blink_q[BLINK_DIV-1]) ? {NDIG{DARK}} : disp_q;
    end

endmodule
